afe_event_sched: RTL and testbench

- Controller for the analogue front-end's asynchronous status lines, such as field-present, pause detect and power-ok.
- Each line passes through a 2-flop synchroniser, then a per-channel debounce filter.
- Filtered edges become pending events. A round-robin scheduler presents them one at a time to the digital core on a valid/ready handshake.
- Sits between the AFE pins and the ISO 14443A protocol/initialisation logic.

---
 rtl/afe_event_sched.sv | 165 ++++++++++++++++
 tb/tb_afe_event_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_event_sched.sv
// AFE status-line event scheduler: synchronises and debounces asynchronous lines,
// then delivers filtered edges one at a time over a round-robin valid/ready port.

module afe_sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift, not a wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

module afe_event_sched #(
    parameter int                NUM_IN    = 4,
    parameter int                DEBOUNCE  = 3,
    parameter logic [NUM_IN-1:0] RESET_VAL = '0,
    localparam int               IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] async_in,
    input  logic [NUM_IN-1:0] enable,
    output logic [NUM_IN-1:0] level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_idx,
    output logic              evt_rising,
    output logic [NUM_IN-1:0] overrun,
    input  logic              overrun_clr
);

    localparam int               CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [NUM_IN-1:0] sync;
    logic [NUM_IN-1:0] lvl_chg;
    logic [NUM_IN-1:0] pending;
    logic [NUM_IN-1:0] pol;
    logic [NUM_IN-1:0] grant_req;
    logic [NUM_IN-1:0] grant_oh;
    logic [NUM_IN-1:0] ovr_set;
    logic [CNT_W-1:0]  cnt [NUM_IN];
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              load;

    afe_sync_2ff #(
        .WIDTH     (NUM_IN),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (async_in),
        .q     (sync)
    );

    // A level flips on the DEBOUNCE-th consecutive cycle the synchronised value disagrees.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lvl_chg[i] = (sync[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // NOTE: the counter array is a handful of flops, so it is reset explicitly like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= RESET_VAL;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level <= level ^ lvl_chg;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync[i] == level[i] || lvl_chg[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search starting just after the last granted channel.
    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        logic                found;
        logic [IDX_W-1:0]    cand;
        grant_req = pending & enable;
        any_req   = |grant_req;
        winner    = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_IN);
            if (!found && grant_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign load = any_req && (!evt_valid || evt_ready);

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            grant_oh[i] = load && (winner == IDX_W'(i));
            ovr_set[i]  = enable[i] && lvl_chg[i] && pending[i] && !grant_oh[i];
        end
    end

    // A fresh edge wins over a same-cycle grant: the channel stays pending with the new polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            pol     <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!enable[i]) begin
                    pending[i] <= 1'b0;
                end else if (lvl_chg[i]) begin
                    pending[i] <= 1'b1;
                    pol[i]     <= sync[i];
                end else if (grant_oh[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            overrun <= (overrun_clr ? '0 : overrun) | ovr_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_idx    <= '0;
            evt_rising <= 1'b0;
            last_grant <= IDX_W'(NUM_IN - 1);
        end else if (load) begin
            evt_valid  <= 1'b1;
            evt_idx    <= winner;
            evt_rising <= pol[winner];
            last_grant <= winner;
        end else if (evt_ready) begin
            evt_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_afe_event_sched.sv
// Bench for afe_event_sched: directed test-plan steps plus random line activity,
// all compared every cycle against a sample-history reference model.

module tb_afe_event_sched;

    localparam int                NUM_IN = 4;
    localparam int                DEB    = 3;
    localparam int                IDX_W  = 2;
    localparam logic [NUM_IN-1:0] RV     = '0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_IN-1:0] async_in = '0;
    logic [NUM_IN-1:0] enable = '1;
    logic [NUM_IN-1:0] level;
    logic              evt_valid;
    logic              evt_ready = 1'b1;
    logic [IDX_W-1:0]  evt_idx;
    logic              evt_rising;
    logic [NUM_IN-1:0] overrun;
    logic              overrun_clr = 1'b0;

    int    checks = 0;
    int    failures = 0;
    string phase = "reset";
    bit    collect = 1'b0;
    int    got[$];

    // Reference model state: raw two-edge input delay, per-channel sample history,
    // and the abstract pending/delivery bookkeeping.
    logic [NUM_IN-1:0] m_d1, m_d2, m_lvl, m_pend, m_pol, m_ovr;
    logic [15:0]       m_hist [NUM_IN];
    logic              m_valid, m_rising;
    int                m_idx, m_last;

    afe_event_sched #(
        .NUM_IN    (NUM_IN),
        .DEBOUNCE  (DEB),
        .RESET_VAL (RV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .async_in    (async_in),
        .enable      (enable),
        .level       (level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_idx     (evt_idx),
        .evt_rising  (evt_rising),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = RV; m_d2 = RV; m_lvl = RV;
        for (int i = 0; i < NUM_IN; i++) m_hist[i] = {16{RV[i]}};
        m_pend = '0; m_pol = '0; m_ovr = '0;
        m_valid = 1'b0; m_rising = 1'b0; m_idx = 0; m_last = NUM_IN - 1;
    endtask

    task automatic model_step();
        logic [NUM_IN-1:0] smp, chg, n_pend, n_pol, set_ovr, req;
        int  win;
        bit  load;
        smp  = m_d2;
        m_d2 = m_d1;
        m_d1 = async_in;
        // A level changes once the last DEB samples all disagree with it.
        for (int i = 0; i < NUM_IN; i++) begin
            m_hist[i] = {m_hist[i][14:0], smp[i]};
            chg[i] = 1'b1;
            for (int k = 0; k < DEB; k++) if (m_hist[i][k] == m_lvl[i]) chg[i] = 1'b0;
        end
        req = m_pend & enable;
        win = -1;
        for (int k = 1; k <= NUM_IN; k++)
            if (win < 0 && req[(m_last + k) % NUM_IN]) win = (m_last + k) % NUM_IN;
        load = (win >= 0) && (!m_valid || evt_ready);
        n_pend = m_pend; n_pol = m_pol; set_ovr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!enable[i]) n_pend[i] = 1'b0;
            else if (chg[i]) begin
                if (m_pend[i] && !(load && win == i)) set_ovr[i] = 1'b1;
                n_pend[i] = 1'b1;
                n_pol[i]  = smp[i];
            end else if (load && win == i) n_pend[i] = 1'b0;
        end
        if (load) begin
            m_valid = 1'b1; m_idx = win; m_rising = m_pol[win]; m_last = win;
        end else if (m_valid && evt_ready) m_valid = 1'b0;
        m_ovr  = (overrun_clr ? '0 : m_ovr) | set_ovr;
        m_lvl  = m_lvl ^ chg;
        m_pend = n_pend;
        m_pol  = n_pol;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("level", level, m_lvl);
        check("valid", evt_valid, m_valid);
        check("overrun", overrun, m_ovr);
        if (m_valid) begin
            check("idx", evt_idx, m_idx);
            check("rising", evt_rising, m_rising);
        end
        if (collect && evt_valid && evt_ready) got.push_back(int'(evt_idx));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check_order(input int e0, input int e1, input int e2);
        int exp_q[3];
        exp_q = '{e0, e1, e2};
        check("order_len", got.size(), 3);
        for (int k = 0; k < got.size() && k < 3; k++) check("order", got[k], exp_q[k]);
        got.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_level", level, RV);
        check("rst_valid", evt_valid, 0);
        check("rst_idx", evt_idx, 0);
        check("rst_rising", evt_rising, 0);
        check("rst_overrun", overrun, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single rising edge: level at edge 5, event for exactly one cycle from edge 6.
        phase = "latency";
        async_in[2] = 1'b1;
        run(4);
        check("lvl2_e4", level[2], 0);
        tick();
        check("lvl2_e5", level[2], 1);
        check("valid_e5", evt_valid, 0);
        tick();
        check("valid_e6", evt_valid, 1);
        check("idx_e6", evt_idx, 2);
        check("rising_e6", evt_rising, 1);
        tick();
        check("valid_e7", evt_valid, 0);
        run(3);

        // Two-cycle glitch never reaches level.
        phase = "glitch";
        async_in[1] = 1'b1;
        run(2);
        async_in[1] = 1'b0;
        run(10);
        check("lvl1", level[1], 0);
        check("noevt", evt_valid, 0);

        // Simultaneous edges, first with last grant on 3, then on 1.
        phase = "rr";
        async_in[3] = 1'b1;
        run(8);
        collect = 1'b1;
        async_in = async_in ^ 4'b1011;
        run(10);
        check_order(0, 1, 3);
        async_in[1] = ~async_in[1];
        run(8);
        got.delete();
        async_in = async_in ^ 4'b1011;
        run(10);
        check_order(3, 0, 1);
        collect = 1'b0;

        // Stalled output, two further edges on channel 0 -> overrun, latest polarity.
        phase = "overrun";
        async_in[0] = 1'b1;
        run(8);
        evt_ready = 1'b0;
        async_in[0] = 1'b0;
        run(8);
        check("held_valid", evt_valid, 1);
        check("held_idx", evt_idx, 0);
        check("held_rising", evt_rising, 0);
        async_in[0] = 1'b1;
        run(8);
        async_in[0] = 1'b0;
        run(8);
        check("held_idx2", evt_idx, 0);
        check("ovr0", overrun[0], 1);
        evt_ready = 1'b1;
        tick();
        check("next_valid", evt_valid, 1);
        check("next_idx", evt_idx, 0);
        check("next_rising", evt_rising, 0);
        tick();
        check("drained", evt_valid, 0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Disabled channel: level tracks, no events; pending dropped on disable.
        phase = "enable";
        enable = 4'b0111;
        async_in[3] = 1'b0;
        run(8);
        check("lvl3", level[3], 0);
        check("dis_valid", evt_valid, 0);
        check("dis_ovr", overrun[3], 0);
        enable = 4'b1111;
        evt_ready = 1'b0;
        async_in[2] = 1'b0;
        run(8);
        async_in[3] = 1'b1;
        run(8);
        enable = 4'b0111;
        run(2);
        enable = 4'b1111;
        evt_ready = 1'b1;
        run(6);
        check("dropped", evt_valid, 0);

        // Asynchronous reset with an event presented and two pending.
        phase = "midreset";
        evt_ready = 1'b0;
        async_in = async_in ^ 4'b0111;
        run(8);
        check("pre_valid", evt_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        async_in = RV;
        evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(10);
        check("post_valid", evt_valid, 0);

        // Random line activity, back-pressure, enables and overrun clears.
        phase = "random";
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, NUM_IN - 1);
                async_in[b] = ~async_in[b];
            end
            evt_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) enable = NUM_IN'($urandom) | NUM_IN'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
